// File: rtl/cpu_issue_arbiter.sv
// Round-robin issue arbiter sharing one sequential mv/mvi/add/sub processor
// between NREQ requesters; drives run/din per instruction phase and returns ack/err.
module cpu_issue_arbiter #(
  parameter int NREQ    = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*9-1:0]        instr,
  input  logic [NREQ*DATA_W-1:0]   imm,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          ack,
  output logic [NREQ-1:0]          err,
  output logic                     busy,
  output logic                     cpu_run,
  output logic [DATA_W-1:0]        cpu_din,
  input  logic                     cpu_done,
  output logic                     cpu_abort,
  output logic [2:0]               dbg_state
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DATA  = 3'd2,
    S_WAIT  = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   own_q;
  logic [8:0]         ir_q;
  logic [DATA_W-1:0]  imm_q;
  logic               err_q;
  logic               to_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic               cnt_hit;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   ptr_next;
  logic [NREQ-1:0]    own_oh;
  int                 scan;

  // cnt_q counts completed execute cycles, so cnt_inc is the 1-based
  // number of the execute cycle currently in progress.
  assign cnt_inc  = cnt_q + 1'b1;
  assign cnt_hit  = (cnt_inc == CNT_W'(TIMEOUT));
  assign ptr_next = (own_q == IDX_W'(NREQ - 1)) ? '0 : own_q + 1'b1;
  assign own_oh   = {{(NREQ-1){1'b0}}, 1'b1} << own_q;
  assign dbg_state = state_q;

  // Rotating priority scan starting at ptr_q.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan = (int'(ptr_q) + k) % NREQ;
      if (!win_found && req[scan]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(scan);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:         if (win_found) state_d = instr[9*win_idx+8] ? S_ACK : S_ISSUE;
      S_ISSUE:        state_d = (ir_q[8:6] == 3'b001) ? S_DATA : S_WAIT;
      S_DATA, S_WAIT: if (cpu_done || cnt_hit) state_d = S_ACK;
      S_ACK:          state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      ir_q    <= '0;
      imm_q   <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (win_found) begin
          own_q <= win_idx;
          ir_q  <= instr[9*win_idx +: 9];
          imm_q <= imm[DATA_W*win_idx +: DATA_W];
          err_q <= instr[9*win_idx+8];
          to_q  <= 1'b0;
        end
        S_ISSUE: cnt_q <= '0;
        S_DATA, S_WAIT: begin
          cnt_q <= cnt_inc;
          // A done arriving on the final allowed cycle still counts as success.
          if (!cpu_done && cnt_hit) begin
            err_q <= 1'b1;
            to_q  <= 1'b1;
          end
        end
        S_ACK: ptr_q <= ptr_next;
        default: ;
      endcase
    end
  end

  // Outputs decode only registered state, never req.
  always_comb begin
    gnt       = '0;
    ack       = '0;
    err       = '0;
    busy      = (state_q != S_IDLE);
    cpu_run   = 1'b0;
    cpu_din   = '0;
    cpu_abort = 1'b0;
    case (state_q)
      S_ISSUE: begin
        gnt     = own_oh;
        cpu_run = 1'b1;
        cpu_din = {{(DATA_W-9){1'b0}}, ir_q};
      end
      S_DATA: begin
        gnt     = own_oh;
        cpu_run = 1'b1;
        cpu_din = imm_q;
      end
      S_WAIT: begin
        gnt     = own_oh;
        cpu_run = 1'b1;
      end
      S_ACK: begin
        gnt       = own_oh;
        ack       = own_oh;
        err       = err_q ? own_oh : '0;
        cpu_abort = to_q;
      end
      default: ;
    endcase
  end

endmodule
